// File: rtl/result_accum.sv
// result_accum: sums DEPTH signed 16-bit samples per window and hands each total downstream.
// Define RESULT_ACCUM_SATURATE_EN for clamping adds with a per-window overflow flag; otherwise adds wrap.
module result_accum #(
  parameter int DEPTH = 8,
  parameter int ACC_W = 24
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    CLEAR,
  input  logic                    IN_VALID,
  input  logic signed [15:0]      IN_DATA,
  output logic                    IN_READY,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic signed [ACC_W-1:0] OUT_SUM,
  output logic                    OUT_OVF
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic                    in_fire_s;
  logic                    last_s;
  logic signed [ACC_W-1:0] sum_s;

  // A held total only blocks new input while the consumer is stalled.
  assign IN_READY  = !CLEAR && ((state_q == ST_ACCUM) || OUT_READY);
  assign in_fire_s = IN_VALID && IN_READY;
  assign last_s    = (cnt_q == CNT_LAST);

`ifdef RESULT_ACCUM_SATURATE_EN
  logic signed [ACC_W:0] sum_wide_s;
  logic                  add_ovf_s;
  logic                  ovf_q, ovf_d;
  logic                  out_ovf_q, out_ovf_d;

  assign sum_wide_s = (ACC_W+1)'(acc_q) + (ACC_W+1)'(IN_DATA);
  assign add_ovf_s  = (sum_wide_s[ACC_W] != sum_wide_s[ACC_W-1]);

  // Clamp to the signed range, direction taken from the true sign of the wide sum.
  always_comb begin
    if (!add_ovf_s) begin
      sum_s = sum_wide_s[ACC_W-1:0];
    end else if (sum_wide_s[ACC_W]) begin
      sum_s = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      sum_s = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Sticky window overflow, snapshotted into the output with the total.
  always_comb begin
    ovf_d     = ovf_q;
    out_ovf_d = out_ovf_q;
    if (CLEAR) begin
      ovf_d = 1'b0;
    end else if (in_fire_s && last_s) begin
      out_ovf_d = ovf_q | add_ovf_s;
      ovf_d     = 1'b0;
    end else if (in_fire_s) begin
      ovf_d = ovf_q | add_ovf_s;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ovf_q     <= 1'b0;
      out_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign OUT_OVF = out_ovf_q;
`else
  assign sum_s   = acc_q + ACC_W'(IN_DATA);
  assign OUT_OVF = 1'b0;
`endif

  // Window control. acc/cnt are zero while FULL, so a sample taken during the
  // output handshake naturally opens the next window (or, with DEPTH 1, closes it).
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    if (CLEAR) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else if (in_fire_s && last_s) begin
      out_sum_d   = sum_s;
      out_valid_d = 1'b1;
      state_d     = ST_FULL;
      acc_d       = '0;
      cnt_d       = '0;
    end else if (in_fire_s) begin
      acc_d       = sum_s;
      cnt_d       = cnt_q + CNT_W'(1);
      out_valid_d = 1'b0;
      state_d     = ST_ACCUM;
    end else if ((state_q == ST_FULL) && OUT_READY) begin
      out_valid_d = 1'b0;
      state_d     = ST_ACCUM;
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_SUM   = out_sum_q;

endmodule
